// File: rtl/alu_pkg.sv
// Shared op codes and sequencer state encoding for the lab-board ALU.
// Imported by the operand sequencer and the ALU itself.
package alu_pkg;

  localparam logic [3:0] OP_AND = 4'd0;
  localparam logic [3:0] OP_OR  = 4'd1;
  localparam logic [3:0] OP_XOR = 4'd2;
  localparam logic [3:0] OP_ADD = 4'd4;
  localparam logic [3:0] OP_SUB = 4'd5;

  typedef enum logic [2:0] {
    S_A    = 3'd0,
    S_B    = 3'd1,
    S_OP   = 3'd2,
    S_EXEC = 3'd3,
    S_SHOW = 3'd4
  } seq_state_e;

  function automatic logic is_legal_op(
    input logic [3:0] op
  );
    case (op)
      OP_AND, OP_OR, OP_XOR,
      OP_ADD, OP_SUB: return 1'b1;
      default:        return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/edge_detect.sv
// Single-bit rising-edge pulse generator.
// A level held high yields one pulse.
module edge_detect (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic pulse
);

  logic prev_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) prev_q <= 1'b0;
    else        prev_q <= d;
  end

  assign pulse = d & ~prev_q;

endmodule

// File: rtl/alu_operand_sequencer.sv
// Collects A, B and op code from switches, drives the ALU,
// and latches result/flags for display.
module alu_operand_sequencer
  import alu_pkg::*;
#(
  parameter int N     = 3,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [N-1:0]     sw,
  input  logic [3:0]       op_sw,
  input  logic             btn_next,
  input  logic             btn_clear,
  output logic [N-1:0]     alu_a,
  output logic [N-1:0]     alu_b,
  output logic [3:0]       alu_ctrl,
  input  logic [N-1:0]     alu_result,
  input  logic             alu_n,
  input  logic             alu_z,
  input  logic             alu_c,
  input  logic             alu_v,
  output logic [N-1:0]     res_q,
  output logic [3:0]       flags_q,
  output logic [N-1:0]     disp_value,
  output logic [2:0]       state_q,
  output logic             valid,
  output logic             op_err,
  output logic             done,
  output logic [CNT_W-1:0] op_count
);

  seq_state_e   st_q;
  logic [N-1:0] a_q;
  logic [N-1:0] b_q;
  logic [3:0]   op_q;
  logic         next_evt;

  edge_detect u_next (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (btn_next),
    .pulse (next_evt)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st_q     <= S_A;
      a_q      <= '0;
      b_q      <= '0;
      op_q     <= '0;
      res_q    <= '0;
      flags_q  <= '0;
      valid    <= 1'b0;
      op_err   <= 1'b0;
      done     <= 1'b0;
      op_count <= '0;
    end else begin
      done <= 1'b0;
      if (btn_clear) begin
        st_q    <= S_A;
        a_q     <= '0;
        b_q     <= '0;
        op_q    <= '0;
        res_q   <= '0;
        flags_q <= '0;
        valid   <= 1'b0;
        op_err  <= 1'b0;
      end else begin
        unique case (st_q)
          S_A: if (next_evt) begin
            a_q  <= sw;
            st_q <= S_B;
          end
          S_B: if (next_evt) begin
            b_q  <= sw;
            st_q <= S_OP;
          end
          S_OP: if (next_evt) begin
            op_q <= op_sw;
            if (is_legal_op(op_sw)) begin
              st_q <= S_EXEC;
            end else begin
              op_err <= 1'b1;
              valid  <= 1'b0;
              st_q   <= S_SHOW;
            end
          end
          // operands have been stable on the ALU for this whole cycle
          S_EXEC: begin
            res_q    <= alu_result;
            flags_q  <= {alu_n, alu_z, alu_c, alu_v};
            valid    <= 1'b1;
            op_err   <= 1'b0;
            done     <= 1'b1;
            op_count <= op_count + CNT_W'(1);
            st_q     <= S_SHOW;
          end
          S_SHOW: if (next_evt) begin
            valid <= 1'b0;
            st_q  <= S_A;
          end
          default: st_q <= S_A;
        endcase
      end
    end
  end

  assign alu_a    = a_q;
  assign alu_b    = b_q;
  assign alu_ctrl = op_q;
  assign state_q  = st_q;

  always_comb begin
    disp_value = '0;
    unique case (st_q)
      S_A, S_B:       disp_value = sw;
      S_OP:           disp_value = a_q;
      S_EXEC, S_SHOW: disp_value = op_err ? '0 : res_q;
      default:        disp_value = '0;
    endcase
  end

endmodule

// File: tb/tb_alu_operand_sequencer.sv
// Directed bench for alu_operand_sequencer with a small
// behavioural 3-bit ALU on the other side of the interface.
module tb_alu_operand_sequencer;

  localparam int N     = 3;
  localparam int CNT_W = 8;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic [N-1:0]     sw = '0;
  logic [3:0]       op_sw = '0;
  logic             btn_next = 1'b0;
  logic             btn_clear = 1'b0;
  logic [N-1:0]     alu_a, alu_b;
  logic [3:0]       alu_ctrl;
  logic [N-1:0]     alu_result;
  logic             alu_n, alu_z, alu_c, alu_v;
  logic [N-1:0]     res_q;
  logic [3:0]       flags_q;
  logic [N-1:0]     disp_value;
  logic [2:0]       state_q;
  logic             valid, op_err, done;
  logic [CNT_W-1:0] op_count;

  int checks = 0;
  int failures = 0;
  int done_cnt = 0;

  always #5 clk = ~clk;

  alu_operand_sequencer #(.N(N), .CNT_W(CNT_W)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .sw         (sw),
    .op_sw      (op_sw),
    .btn_next   (btn_next),
    .btn_clear  (btn_clear),
    .alu_a      (alu_a),
    .alu_b      (alu_b),
    .alu_ctrl   (alu_ctrl),
    .alu_result (alu_result),
    .alu_n      (alu_n),
    .alu_z      (alu_z),
    .alu_c      (alu_c),
    .alu_v      (alu_v),
    .res_q      (res_q),
    .flags_q    (flags_q),
    .disp_value (disp_value),
    .state_q    (state_q),
    .valid      (valid),
    .op_err     (op_err),
    .done       (done),
    .op_count   (op_count)
  );

  // behavioural ALU: C is carry-out of a+b or a+~b+1
  logic [N:0] sum;
  always_comb begin
    sum        = '0;
    alu_result = '0;
    alu_c      = 1'b0;
    alu_v      = 1'b0;
    case (alu_ctrl)
      4'd0: alu_result = alu_a & alu_b;
      4'd1: alu_result = alu_a | alu_b;
      4'd2: alu_result = alu_a ^ alu_b;
      4'd4: begin
        sum        = {1'b0, alu_a} + {1'b0, alu_b};
        alu_result = sum[N-1:0];
        alu_c      = sum[N];
        alu_v      = (alu_a[N-1] == alu_b[N-1]) &&
                     (alu_result[N-1] != alu_a[N-1]);
      end
      4'd5: begin
        sum        = {1'b0, alu_a} + {1'b0, ~alu_b} + 1'b1;
        alu_result = sum[N-1:0];
        alu_c      = sum[N];
        alu_v      = (alu_a[N-1] != alu_b[N-1]) &&
                     (alu_result[N-1] != alu_a[N-1]);
      end
      default: alu_result = '0;
    endcase
    alu_n = alu_result[N-1];
    alu_z = (alu_result == '0);
  end

  always @(negedge clk) if (done === 1'b1) done_cnt++;

  task automatic press();
    @(negedge clk) btn_next = 1'b1;
    @(negedge clk) btn_next = 1'b0;
  endtask

  task automatic load(input logic [N-1:0] a,
                      input logic [N-1:0] b,
                      input logic [3:0] op);
    sw = a;
    press();
    sw = b;
    press();
    op_sw = op;
    press();
  endtask

  task automatic test_reset();
    sw = '0;
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if (state_q !== 3'd0 || valid !== 1'b0 || op_err !== 1'b0 || done !== 1'b0) begin
      failures++;
      $display("FAIL reset_ctrl: state=%0d valid=%b err=%b done=%b, want 0/0/0/0",
               state_q, valid, op_err, done);
    end
    checks++;
    if ({alu_a, alu_b, alu_ctrl, res_q, flags_q, disp_value} !== '0 || op_count !== '0) begin
      failures++;
      $display("FAIL reset_data: a=%0d b=%0d ctrl=%0d res=%0d flags=%b disp=%0d cnt=%0d, want all 0",
               alu_a, alu_b, alu_ctrl, res_q, flags_q, disp_value, op_count);
    end
  endtask

  task automatic test_add();
    int d0;
    d0 = done_cnt;
    load(3'd3, 3'd5, 4'd4);
    checks++;
    if (state_q !== 3'd3 || alu_a !== 3'd3 || alu_b !== 3'd5 || alu_ctrl !== 4'd4) begin
      failures++;
      $display("FAIL add_exec: state=%0d a=%0d b=%0d ctrl=%0d, want 3/3/5/4",
               state_q, alu_a, alu_b, alu_ctrl);
    end
    @(negedge clk);
    checks++;
    if (state_q !== 3'd4 || res_q !== 3'b000 || flags_q !== 4'b0110 || valid !== 1'b1 || done !== 1'b1) begin
      failures++;
      $display("FAIL add_show: state=%0d res=%b flags=%b valid=%b done=%b, want 4/000/0110/1/1",
               state_q, res_q, flags_q, valid, done);
    end
    repeat (3) @(negedge clk);
    checks++;
    if (done_cnt - d0 !== 1 || op_count !== 8'd1 || disp_value !== 3'd0) begin
      failures++;
      $display("FAIL add_done: pulses=%0d cnt=%0d disp=%0d, want 1/1/0",
               done_cnt - d0, op_count, disp_value);
    end
    press();
  endtask

  task automatic test_sub();
    load(3'd2, 3'd3, 4'd5);
    @(negedge clk);
    checks++;
    if (res_q !== 3'b111 || flags_q !== 4'b1000 || valid !== 1'b1 || disp_value !== 3'b111) begin
      failures++;
      $display("FAIL sub_show: res=%b flags=%b valid=%b disp=%b, want 111/1000/1/111",
               res_q, flags_q, valid, disp_value);
    end
    press();
    checks++;
    if (state_q !== 3'd0 || valid !== 1'b0 || op_count !== 8'd2) begin
      failures++;
      $display("FAIL sub_leave: state=%0d valid=%b cnt=%0d, want 0/0/2",
               state_q, valid, op_count);
    end
  endtask

  task automatic test_illegal();
    int d0;
    d0 = done_cnt;
    load(3'd1, 3'd2, 4'd3);
    checks++;
    if (state_q !== 3'd4 || op_err !== 1'b1 || valid !== 1'b0 || disp_value !== 3'd0) begin
      failures++;
      $display("FAIL illegal_show: state=%0d err=%b valid=%b disp=%0d, want 4/1/0/0",
               state_q, op_err, valid, disp_value);
    end
    repeat (3) @(negedge clk);
    checks++;
    if (done_cnt !== d0 || op_count !== 8'd2) begin
      failures++;
      $display("FAIL illegal_count: pulses=%0d cnt=%0d, want 0/2",
               done_cnt - d0, op_count);
    end
    press();
  endtask

  task automatic test_held_button();
    int trans;
    logic [2:0] prev;
    trans = 0;
    sw = 3'd6;
    prev = state_q;
    @(negedge clk) btn_next = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (state_q !== prev) trans++;
      prev = state_q;
    end
    btn_next = 1'b0;
    @(negedge clk);
    checks++;
    if (trans !== 1 || state_q !== 3'd1 || alu_a !== 3'd6) begin
      failures++;
      $display("FAIL held_button: transitions=%0d state=%0d a=%0d, want 1/1/6",
               trans, state_q, alu_a);
    end
  endtask

  task automatic test_clear();
    @(negedge clk);
    btn_clear = 1'b1;
    btn_next  = 1'b1;
    @(negedge clk);
    btn_clear = 1'b0;
    btn_next  = 1'b0;
    checks++;
    if (state_q !== 3'd0 || alu_a !== 3'd0 || op_count !== 8'd2 || valid !== 1'b0) begin
      failures++;
      $display("FAIL clear: state=%0d a=%0d cnt=%0d valid=%b, want 0/0/2/0",
               state_q, alu_a, op_count, valid);
    end
  endtask

  task automatic test_async_reset();
    int d0;
    load(3'd3, 3'd5, 4'd4);
    sw = '0;
    d0 = done_cnt;
    checks++;
    if (state_q !== 3'd3) begin
      failures++;
      $display("FAIL areset_pre: state=%0d, want 3", state_q);
    end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (state_q !== 3'd0 || alu_a !== 3'd0 || res_q !== 3'd0 || op_count !== 8'd0 || valid !== 1'b0) begin
      failures++;
      $display("FAIL areset_now: state=%0d a=%0d res=%0d cnt=%0d valid=%b, want all 0",
               state_q, alu_a, res_q, op_count, valid);
    end
    @(negedge clk) rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if (res_q !== 3'd0 || flags_q !== 4'd0 || done_cnt !== d0 || state_q !== 3'd0) begin
      failures++;
      $display("FAIL areset_after: res=%0d flags=%b pulses=%0d state=%0d, want 0/0/0/0",
               res_q, flags_q, done_cnt - d0, state_q);
    end
  endtask

  task automatic test_wrap();
    done_cnt = 0;
    for (int i = 0; i < 256; i++) begin
      load(3'd1, 3'd1, 4'd4);
      @(negedge clk);
      if (i == 254) begin
        checks++;
        if (op_count !== 8'd255 || res_q !== 3'd2) begin
          failures++;
          $display("FAIL wrap_255: cnt=%0d res=%0d, want 255/2", op_count, res_q);
        end
      end
      press();
    end
    checks++;
    if (op_count !== 8'd0 || done_cnt !== 256) begin
      failures++;
      $display("FAIL wrap_0: cnt=%0d pulses=%0d, want 0/256", op_count, done_cnt);
    end
  endtask

  initial begin
    test_reset();
    test_add();
    test_sub();
    test_illegal();
    test_held_button();
    test_clear();
    test_async_reset();
    test_wrap();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
